// File: rtl/seq_detector_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Lengths and masks are computed at 32 bits; callers truncate to their own widths.
package seq_detector_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

    localparam logic [MAX_LEN_DEF-1:0] DEFAULT_PATTERN_DEF = 8'b0000_1011;
    localparam int                     DEFAULT_LEN_DEF     = 4;

    // A zero-length pattern would match nothing meaningful, so it becomes 1.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    function automatic logic [31:0] len_mask(input int unsigned len);
        if (len >= 32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with synchronous clear and a sticky saturation flag.
// Clear wins over a simultaneous increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && (count_q != '1)) begin
                count_d = count_q + W'(1);
            end
            sat_d = sat_q | (count_d == '1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with a registered match pulse,
// overlapping/non-overlapping modes, sample enable and a saturating match counter.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int                   MAX_LEN         = MAX_LEN_DEF,
    parameter int                   CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(DEFAULT_PATTERN_DEF),
    parameter int                   DEFAULT_LEN     = DEFAULT_LEN_DEF
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           sequence_in,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           clear,
    output logic                           detector_out,
    output logic [CNT_W-1:0]               match_count,
    output logic                           count_sat,
    output logic                           armed
);

    localparam int            LW      = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] FULL    = LW'(MAX_LEN);
    localparam logic [LW-1:0] RST_LEN = LW'(clamp_len(DEFAULT_LEN, MAX_LEN));

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               det_q, det_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_inc;
    logic               sample;
    logic               hit;

    // Match is judged on the history as it will look after this sample is shifted in.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], sequence_in};
        fill_inc   = (fill_q == FULL) ? FULL : fill_q + LW'(1);
        mask       = MAX_LEN'(len_mask(32'(len_q)));
        sample     = enable & ~cfg_load;
        hit        = sample
                   && ((hist_shift & mask) == (pat_q & mask))
                   && (fill_inc >= len_q);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        det_d  = hit;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = LW'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (sample) begin
            hist_d = hist_shift;
            // Non-overlapping mode demands a full set of fresh bits after each match.
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PATTERN;
            len_q  <= RST_LEN;
            ovl_q  <= 1'b1;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            det_q  <= det_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (hit),
        .clr     (clear),
        .count   (match_count),
        .sat     (count_sat)
    );

    assign detector_out = det_q;
    assign armed        = (fill_q >= len_q);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: table vectors, directed corner sequences and random
// traffic, all checked against a queue-based model of the detection rules.
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       sequence_in;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       clear;

    logic       det_a, sat_a, armed_a;
    logic [7:0] cnt_a;
    logic       det_b, sat_b, armed_b;
    logic [1:0] cnt_b;

    always #5 clock = ~clock;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sequence_in(sequence_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clear(clear), .detector_out(det_a),
        .match_count(cnt_a), .count_sat(sat_a), .armed(armed_a)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sequence_in(sequence_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clear(clear), .detector_out(det_b),
        .match_count(cnt_b), .count_sat(sat_b), .armed(armed_b)
    );

    int tests = 0;
    int fails = 0;

    // Model: bits accepted since the last point where progress was discarded.
    bit         mq[$];
    int         raw;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_det;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        raw   = 0;
        m_pat = 8'h0B;
        m_len = 4;
        m_ovl = 1'b1;
        m_det = 1'b0;
    endtask

    function automatic bit tail_match();
        int n = mq.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (mq[n-1-i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_all();
        chk("det_a",   32'(det_a),   32'(m_det));
        chk("det_b",   32'(det_b),   32'(m_det));
        chk("cnt8",    32'(cnt_a),   (raw > 255) ? 255 : raw);
        chk("sat8",    32'(sat_a),   32'(raw >= 255));
        chk("cnt2",    32'(cnt_b),   (raw > 3) ? 3 : raw);
        chk("sat2",    32'(sat_b),   32'(raw >= 3));
        chk("armed",   32'(armed_a), 32'(mq.size() >= m_len));
    endtask

    task automatic step(input bit en, input bit din, input bit ld, input logic [7:0] pat,
                        input int len, input bit ovl, input bit clr);
        enable      = en;
        sequence_in = din;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ovl;
        clear       = clr;
        @(posedge clock);
        m_det = 1'b0;
        if (ld) begin
            m_pat = pat;
            m_len = (len == 0) ? 1 : ((len > 8) ? 8 : len);
            m_ovl = ovl;
            mq.delete();
        end else if (en) begin
            mq.push_back(din);
            if (tail_match()) begin
                m_det = 1'b1;
                raw++;
                if (!m_ovl) mq.delete();
            end
        end
        if (clr) raw = 0;
        while (mq.size() > 32) mq.delete(0);
        #1;
        check_all();
    endtask

    task automatic bit_in(input bit din, input bit clr = 1'b0);
        step(1'b1, din, 1'b0, 8'h00, 0, 1'b0, clr);
    endtask

    task automatic load(input logic [7:0] pat, input int len, input bit ovl, input bit clr);
        step(1'b1, 1'b1, 1'b1, pat, len, ovl, clr);
    endtask

    typedef struct {
        bit din;
        bit exp_det;
        int exp_cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1};
        tbl[4] = '{1'b0, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b0, 1};
        tbl[6] = '{1'b1, 1'b1, 2};

        reset_n     = 1'b0;
        enable      = 1'b0;
        sequence_in = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        clear       = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Default 1011 overlapping detection.
        for (int i = 0; i < 7; i++) begin
            bit_in(tbl[i].din);
            chk("tbl_det", 32'(det_a), 32'(tbl[i].exp_det));
            chk("tbl_cnt", 32'(cnt_a), 32'(tbl[i].exp_cnt));
        end

        // Non-overlapping mode, load and clear on the same edge.
        load(8'h0B, 4, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) bit_in(tbl[i].din);
        chk("nonovl_cnt", 32'(cnt_a), 32'd1);

        // Enable gap holds partial progress.
        load(8'h0B, 4, 1'b1, 1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b0, 8'h00, 0, 1'b0, 1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("gap_det", 32'(det_a), 32'd1);

        // Saturation in the 2-bit build, then clear racing a match.
        load(8'h0B, 4, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        end
        chk("sat_cnt2", 32'(cnt_b), 32'd3);
        chk("sat_flag2", 32'(sat_b), 32'd1);
        chk("sat_cnt8", 32'(cnt_a), 32'd5);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        bit_in(1'b1, 1'b1);
        chk("clr_det", 32'(det_a), 32'd1);
        chk("clr_cnt2", 32'(cnt_b), 32'd0);
        chk("clr_sat2", 32'(sat_b), 32'd0);

        // Async reset mid-pattern.
        load(8'h0B, 4, 1'b1, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_det", 32'(det_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_armed", 32'(armed_a), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        bit_in(1'b1);
        chk("post_rst_det", 32'(det_a), 32'd0);

        // Full-width alternating pattern, overlapping.
        load(8'hAA, 8, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            bit_in(1'(i % 2));
            chk("alt8_det", 32'(det_a), 32'((i >= 8) && (i % 2 == 0)));
        end

        // Length 0 clamps to 1: every accepted 1 pulses.
        load(8'h01, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bit b = 1'($urandom);
            bit_in(b);
            chk("len1_det", 32'(det_a), 32'(b));
        end

        // Length above the maximum clamps to 8.
        load(8'hAA, 15, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) bit_in(1'(i % 2));
        chk("clamp_det", 32'(det_a), 32'd1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 3) begin
                int l = (r == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
                load(8'($urandom), l, 1'($urandom), ($urandom_range(0, 3) == 0));
            end else begin
                step((r % 4) != 0, 1'($urandom), 1'b0, 8'h00, 0, 1'b0, (r == 99));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial bit-pattern detector with Moore-style output.
- Generalises the fixed "1011" detector:
  - pattern length up to MAX_LEN, loadable at runtime;
  - selectable overlapping or non-overlapping detection;
  - sample-enable qualifier;
  - saturating match counter.
- Sits on a serial bit stream; feeds status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, match counter width.
- DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset (LSB = last bit received).
- DEFAULT_LEN, 4, pattern length loaded at reset.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  sequence_in is sampled only on edges where enable=1.
- sequence_in  input  1  serial data bit.
- cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this edge.
- cfg_pattern  input  MAX_LEN  new pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  input  $clog2(MAX_LEN+1)  new length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear  input  1  synchronous clear of match_count and count_sat.
- detector_out  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  number of matches, saturating.
- count_sat  output  1  sticky; set when match_count reaches all-ones.
- armed  output  1  fill >= active length (enough bits held to match).

Behaviour:
- Reset (reset_n=0, immediate):
  - history=0, fill=0, pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=1.
  - detector_out=0, match_count=0, count_sat=0, armed=0.
- Internal state:
  - history: MAX_LEN shift register; on an accepted sample, history <= {history[MAX_LEN-2:0], sequence_in}.
  - fill: counter, increments per accepted sample, saturates at MAX_LEN.
- Match condition, evaluated on the post-shift history of an accepted sample:
  - (history & mask) == (pattern & mask), where mask = low len bits set;
  - and post-increment fill >= len.
- detector_out:
  - Is 1 for exactly the one cycle following the edge that accepted the completing bit; 0 otherwise.
  - Is not held by enable=0.
  - Latency: last pattern bit sampled at edge N gives detector_out high between edges N and N+1.
- On a match:
  - match_count increments (saturating at 2^CNT_W-1); count_sat set when the count reaches max.
  - overlap=0: fill <= 0 on the same edge, so the next match needs len fresh bits.
  - overlap=1: fill continues, so a pattern tail can start the next match.
- enable=0: history, fill and counter hold; detector_out still drops after its one cycle.
- cfg_load=1:
  - Latches the configuration; fill <= 0; history <= 0; detector_out <= 0.
  - No sample is accepted that edge even if enable=1, and no match is possible that edge.
- cfg_len clamping: 0 becomes 1; values above MAX_LEN become MAX_LEN.
- clear=1:
  - match_count <= 0 and count_sat <= 0.
  - Takes priority over a simultaneous match: that match is not counted, but detector_out still pulses.
  - Does not touch history or fill.
- Simultaneous cfg_load and clear: both take effect.
- armed = (fill >= len), combinational from registers.
- Async reset mid-pattern discards all partial progress; outputs go low immediately and asynchronously.

Decomposition:
- Package seq_detector_pkg:
  - clamp_len function;
  - localparams LEN_W = $clog2(MAX_LEN+1) and mask-generation function;
  - default pattern/length constants.
- Sub-module sat_counter (CNT_W): increment, clear priority, saturation, sticky sat flag. Reused by other status blocks.

Test Plan:
- Default config (1011, overlap=1), enable=1, bits 1,0,1,1,0,1,1 -> detector_out pulses after bit 4 and bit 7; match_count=2.
- cfg_load pattern 1011, len 4, overlap=0; same stream -> single pulse after bit 4; match_count=1.
- Bits 1,0 with enable=1, then 3 cycles enable=0, then 1,1 -> one pulse after the final accepted bit; no pulse during the gap.
- CNT_W=2 build, 5 matches -> match_count=3, count_sat=1.
- Then clear asserted on the same edge as a 6th match -> match_count=0, count_sat=0, detector_out still pulses.
- Feed 1,0,1, pulse reset_n low mid-cycle, then 1 -> outputs 0 during reset; no pulse afterwards (fill=1 < 4).
- cfg_load 8-bit pattern 10101010, len 8, overlap=1; stream of 12 alternating bits starting with 1 -> pulses after bits 8, 10, 12.
- cfg_load with cfg_len=0 and pattern LSB=1 -> every accepted 1 pulses.
